// File: rtl/rob_pkg.sv
// Shared constants and entry layout for the reorder buffer (rob_commit, rob_ptr).
package rob_pkg;

   localparam int unsigned ROB_DEPTH = 8;
   localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);

   localparam logic [3:0] OPC_SUB   = 4'b0000;
   localparam logic [3:0] OPC_ADD   = 4'b0001;
   localparam logic [3:0] OPC_MUL   = 4'b0010;
   localparam logic [3:0] OPC_DIV   = 4'b0011;
   localparam logic [3:0] OPC_STORE = 4'b0100;
   localparam logic [3:0] OPC_LOAD  = 4'b0101;

   typedef struct packed {
      logic       occupied;
      logic       done;
      logic [3:0] opcode;
      logic [3:0] dest;
      logic [7:0] value;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Modular ROB pointer: advances by i_inc each clock, wraps naturally at 2**W.
module rob_ptr
   import rob_pkg::*;
#(
   parameter int unsigned W  = TAG_W,
   parameter int unsigned KW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [KW-1:0] i_inc,
   output logic [W-1:0]  o_ptr
);

   logic [W-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ptr <= '0;
      else        r_ptr <= r_ptr + W'(i_inc);
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer storage with in-order retire; ROB_DUAL_RETIRE_EN adds a second retire lane.
module rob_commit
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [3:0]               alloc_opcode,
   input  logic [3:0]               alloc_dest,
   output logic [$clog2(DEPTH)-1:0] alloc_tag,
   input  logic                     cdb_valid,
   input  logic [$clog2(DEPTH)-1:0] cdb_tag,
   input  logic [7:0]               cdb_value,
   input  logic [$clog2(DEPTH)-1:0] rd_tag_a,
   input  logic [$clog2(DEPTH)-1:0] rd_tag_b,
   output logic                     rd_ready_a,
   output logic                     rd_ready_b,
   output logic [7:0]               rd_value_a,
   output logic [7:0]               rd_value_b,
   output logic                     ret_valid,
   output logic [$clog2(DEPTH)-1:0] ret_tag,
   output logic [3:0]               ret_dest,
   output logic [7:0]               ret_value,
   output logic                     ret_is_store,
`ifdef ROB_DUAL_RETIRE_EN
   output logic                     ret1_valid,
   output logic [$clog2(DEPTH)-1:0] ret1_tag,
   output logic [3:0]               ret1_dest,
   output logic [7:0]               ret1_value,
   output logic                     ret1_is_store,
`endif
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned TW = $clog2(DEPTH);
   localparam int unsigned CW = TW + 1;

   rob_entry_t    r_rob [DEPTH];
   logic [CW-1:0] r_count;
   logic [TW-1:0] w_head;
   logic [TW-1:0] w_tail;
   logic          w_accept;
   logic          w_ret0;
   logic          w_ret1;
   logic [1:0]    w_nret;

   assign alloc_ready = (r_count < CW'(DEPTH));
   assign w_accept    = alloc_valid && alloc_ready;
   assign w_ret0      = r_rob[w_head].occupied && r_rob[w_head].done;

`ifdef ROB_DUAL_RETIRE_EN
   logic [TW-1:0] w_head1;
   assign w_head1 = w_head + 1'b1;
   assign w_ret1  = w_ret0 && r_rob[w_head1].occupied && r_rob[w_head1].done;
`else
   assign w_ret1  = 1'b0;
`endif

   assign w_nret = {1'b0, w_ret0} + {1'b0, w_ret1};

   rob_ptr #(.W(TW), .KW(2)) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc ({1'b0, w_accept}),
      .o_ptr (w_tail)
   );

   rob_ptr #(.W(TW), .KW(2)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_nret),
      .o_ptr (w_head)
   );

   // Alloc only targets a free slot and CDB only hits occupied ones, so the writes never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_rob[i] <= '0;
      end else begin
         if (w_accept) begin
            r_rob[w_tail] <= '{occupied: 1'b1, done: 1'b0, opcode: alloc_opcode,
                               dest: alloc_dest, value: 8'h00};
         end
         if (cdb_valid && r_rob[cdb_tag].occupied) begin
            r_rob[cdb_tag].done  <= 1'b1;
            r_rob[cdb_tag].value <= cdb_value;
         end
         if (w_ret0) r_rob[w_head].occupied <= 1'b0;
`ifdef ROB_DUAL_RETIRE_EN
         if (w_ret1) r_rob[w_head1].occupied <= 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_count <= '0;
      else        r_count <= r_count + CW'(w_accept) - CW'(w_nret);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_valid    <= 1'b0;
         ret_tag      <= '0;
         ret_dest     <= '0;
         ret_value    <= '0;
         ret_is_store <= 1'b0;
      end else begin
         ret_valid <= w_ret0;
         if (w_ret0) begin
            ret_tag      <= w_head;
            ret_dest     <= r_rob[w_head].dest;
            ret_value    <= r_rob[w_head].value;
            ret_is_store <= (r_rob[w_head].opcode == OPC_STORE);
         end
      end
   end

`ifdef ROB_DUAL_RETIRE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret1_valid    <= 1'b0;
         ret1_tag      <= '0;
         ret1_dest     <= '0;
         ret1_value    <= '0;
         ret1_is_store <= 1'b0;
      end else begin
         ret1_valid <= w_ret1;
         if (w_ret1) begin
            ret1_tag      <= w_head1;
            ret1_dest     <= r_rob[w_head1].dest;
            ret1_value    <= r_rob[w_head1].value;
            ret1_is_store <= (r_rob[w_head1].opcode == OPC_STORE);
         end
      end
   end
`endif

   assign alloc_tag  = w_tail;
   assign count      = r_count;
   assign empty      = (r_count == '0);
   assign rd_ready_a = r_rob[rd_tag_a].occupied && r_rob[rd_tag_a].done;
   assign rd_ready_b = r_rob[rd_tag_b].occupied && r_rob[rd_tag_b].done;
   assign rd_value_a = rd_ready_a ? r_rob[rd_tag_a].value : '0;
   assign rd_value_b = rd_ready_b ? r_rob[rd_tag_b].value : '0;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit against a program-order queue model; honours ROB_DUAL_RETIRE_EN.
module tb_rob_commit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       alloc_valid, alloc_ready;
   logic [3:0] alloc_opcode, alloc_dest;
   logic [2:0] alloc_tag;
   logic       cdb_valid;
   logic [2:0] cdb_tag;
   logic [7:0] cdb_value;
   logic [2:0] rd_tag_a, rd_tag_b;
   logic       rd_ready_a, rd_ready_b;
   logic [7:0] rd_value_a, rd_value_b;
   logic       ret_valid, ret_is_store;
   logic [2:0] ret_tag;
   logic [3:0] ret_dest;
   logic [7:0] ret_value;
   logic [3:0] count;
   logic       empty;
`ifdef ROB_DUAL_RETIRE_EN
   logic       ret1_valid, ret1_is_store;
   logic [2:0] ret1_tag;
   logic [3:0] ret1_dest;
   logic [7:0] ret1_value;
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   always #5 clk = ~clk;

   rob_commit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_valid  (alloc_valid),
      .alloc_ready  (alloc_ready),
      .alloc_opcode (alloc_opcode),
      .alloc_dest   (alloc_dest),
      .alloc_tag    (alloc_tag),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .cdb_value    (cdb_value),
      .rd_tag_a     (rd_tag_a),
      .rd_tag_b     (rd_tag_b),
      .rd_ready_a   (rd_ready_a),
      .rd_ready_b   (rd_ready_b),
      .rd_value_a   (rd_value_a),
      .rd_value_b   (rd_value_b),
      .ret_valid    (ret_valid),
      .ret_tag      (ret_tag),
      .ret_dest     (ret_dest),
      .ret_value    (ret_value),
      .ret_is_store (ret_is_store),
`ifdef ROB_DUAL_RETIRE_EN
      .ret1_valid   (ret1_valid),
      .ret1_tag     (ret1_tag),
      .ret1_dest    (ret1_dest),
      .ret1_value   (ret1_value),
      .ret1_is_store(ret1_is_store),
`endif
      .count        (count),
      .empty        (empty)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: per-tag contents plus a queue holding tags in program order.
   bit         m_occ  [8];
   bit         m_done [8];
   logic [3:0] m_opc  [8];
   logic [3:0] m_dest [8];
   logic [7:0] m_val  [8];
   int         m_order[$];
   int         m_next;
   logic       e_rv, e_rs, e1_rv, e1_rs;
   logic [2:0] e_rt, e1_rt;
   logic [3:0] e_rd, e1_rd;
   logic [7:0] e_rval, e1_rval;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_occ[i] = 0; m_done[i] = 0; m_opc[i] = '0; m_dest[i] = '0; m_val[i] = '0;
      end
      m_order.delete();
      m_next = 0;
      e_rv = 0; e_rs = 0; e_rt = '0; e_rd = '0; e_rval = '0;
      e1_rv = 0; e1_rs = 0; e1_rt = '0; e1_rd = '0; e1_rval = '0;
   endfunction

   function automatic void model_edge(input logic av, input logic [3:0] aop, input logic [3:0] adst,
                                      input logic cv, input logic [2:0] ct, input logic [7:0] cval);
      int nret = 0;
      int t;
      if (m_order.size() > 0 && m_done[m_order[0]]) nret = 1;
      if (DUAL && nret == 1 && m_order.size() > 1 && m_done[m_order[1]]) nret = 2;
      e_rv  = (nret >= 1);
      e1_rv = (nret == 2);
      if (nret >= 1) begin
         t = m_order[0];
         e_rt = 3'(t); e_rd = m_dest[t]; e_rval = m_val[t]; e_rs = (m_opc[t] == 4'b0100);
      end
      if (nret == 2) begin
         t = m_order[1];
         e1_rt = 3'(t); e1_rd = m_dest[t]; e1_rval = m_val[t]; e1_rs = (m_opc[t] == 4'b0100);
      end
      if (cv && m_occ[ct]) begin
         m_done[ct] = 1; m_val[ct] = cval;
      end
      if (av && m_order.size() < 8) begin
         m_occ[m_next] = 1; m_done[m_next] = 0; m_opc[m_next] = aop;
         m_dest[m_next] = adst; m_val[m_next] = '0;
         m_order.push_back(m_next);
         m_next = (m_next + 1) % 8;
      end
      for (int k = 0; k < nret; k++) begin
         t = m_order.pop_front();
         m_occ[t] = 0; m_done[t] = 0;
      end
   endfunction

   // One clock: drive after negedge, check combinational view, clock, check retire registers.
   task automatic step(input logic av, input logic [3:0] aop, input logic [3:0] adst,
                       input logic cv, input logic [2:0] ct, input logic [7:0] cval,
                       input logic [2:0] ra, input logic [2:0] rb);
      alloc_valid = av; alloc_opcode = aop; alloc_dest = adst;
      cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
      rd_tag_a = ra; rd_tag_b = rb;
      #1;
      check("count", count, m_order.size());
      check("empty", empty, m_order.size() == 0);
      check("alloc_ready", alloc_ready, m_order.size() < 8);
      check("alloc_tag", alloc_tag, m_next);
      check("rd_ready_a", rd_ready_a, m_occ[ra] && m_done[ra]);
      check("rd_value_a", rd_value_a, (m_occ[ra] && m_done[ra]) ? m_val[ra] : 8'h00);
      check("rd_ready_b", rd_ready_b, m_occ[rb] && m_done[rb]);
      check("rd_value_b", rd_value_b, (m_occ[rb] && m_done[rb]) ? m_val[rb] : 8'h00);
      model_edge(av, aop, adst, cv, ct, cval);
      @(posedge clk);
      #1;
      check("ret_valid", ret_valid, e_rv);
      check("ret_tag", ret_tag, e_rt);
      check("ret_dest", ret_dest, e_rd);
      check("ret_value", ret_value, e_rval);
      check("ret_is_store", ret_is_store, e_rs);
`ifdef ROB_DUAL_RETIRE_EN
      check("ret1_valid", ret1_valid, e1_rv);
      check("ret1_tag", ret1_tag, e1_rt);
      check("ret1_dest", ret1_dest, e1_rd);
      check("ret1_value", ret1_value, e1_rval);
      check("ret1_is_store", ret1_is_store, e1_rs);
`endif
      @(negedge clk);
      cdb_valid = 1'b0; alloc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'h0, 4'h0, 0, 3'd0, 8'h00, 3'd0, 3'd0);
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Reset asserted between edges must clear state immediately, without waiting for a clock.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_ret_valid", ret_valid, 0);
      check("arst_empty", empty, 1);
      check("arst_ready", alloc_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int t;
      logic       av, cv;
      logic [2:0] ct;
      rst_n = 1'b0;
      alloc_valid = 0; alloc_opcode = '0; alloc_dest = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_value = '0; rd_tag_a = '0; rd_tag_b = '0;
      model_reset();
      #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_ready", alloc_ready, 1);
      check("rst_ret_valid", ret_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill, overflow attempt, then alloc on the retire edge while full.
      for (int i = 0; i < 8; i++) step(1, 4'h1, 4'(i + 1), 0, 3'd0, 8'h00, 3'(i), 3'd0);
      check("fill_count", count, 8);
      check("fill_ready", alloc_ready, 0);
      step(1, 4'h1, 4'hF, 0, 3'd0, 8'h00, 3'd0, 3'd0);
      check("ninth_ignored", count, 8);
      step(0, 4'h0, 4'h0, 1, 3'd0, 8'h11, 3'd0, 3'd1);
      step(1, 4'h2, 4'h9, 0, 3'd0, 8'h00, 3'd0, 3'd0);
      check("retire_edge_reject", count, 7);
      check("wrap_tag", alloc_tag, 0);
      step(1, 4'h2, 4'h9, 0, 3'd0, 8'h00, 3'd0, 3'd0);
      check("wrap_accept", count, 8);
      for (int i = 1; i < 9; i++) step(0, 4'h0, 4'h0, 1, 3'(i % 8), 8'(8'h30 + i), 3'(i % 8), 3'd0);
      idle(10);
      check("drain_empty", empty, 1);

      // Out-of-order completion, in-order retire.
      sync_reset();
      step(1, 4'h1, 4'h5, 0, 3'd0, 8'h00, 3'd0, 3'd1);
      step(1, 4'h1, 4'h6, 0, 3'd0, 8'h00, 3'd0, 3'd1);
      step(0, 4'h0, 4'h0, 1, 3'd1, 8'h22, 3'd0, 3'd1);
      step(0, 4'h0, 4'h0, 1, 3'd0, 8'h11, 3'd0, 3'd1);
      idle(1);
      check("order_tag0", ret_tag, 0);
      check("order_val0", ret_value, 8'h11);
`ifdef ROB_DUAL_RETIRE_EN
      check("order_tag1", ret1_tag, 1);
      check("order_val1", ret1_value, 8'h22);
`else
      idle(1);
      check("order_tag1", ret_tag, 1);
      check("order_val1", ret_value, 8'h22);
`endif
      idle(1);
      check("order_empty", empty, 1);

      // Store retire, then async reset while the pulse is high.
      t = m_next;
      step(1, 4'b0100, 4'd3, 0, 3'd0, 8'h00, 3'(t), 3'd0);
      step(0, 4'h0, 4'h0, 1, 3'(t), 8'h77, 3'(t), 3'd0);
      idle(1);
      check("store_valid", ret_valid, 1);
      check("store_flag", ret_is_store, 1);
      check("store_dest", ret_dest, 3);
      async_reset();

      // Operand lookup: pending, then ready; CDB to an empty slot changes nothing.
      step(1, 4'h5, 4'h7, 0, 3'd0, 8'h00, 3'd0, 3'd5);
      step(0, 4'h0, 4'h0, 0, 3'd0, 8'h00, 3'd0, 3'd5);
      check("rd_pending", rd_ready_a, 0);
      step(0, 4'h0, 4'h0, 1, 3'd0, 8'h5A, 3'd0, 3'd5);
      check("rd_ready", rd_ready_a, 1);
      check("rd_value", rd_value_a, 8'h5A);
      step(0, 4'h0, 4'h0, 1, 3'd5, 8'hEE, 3'd0, 3'd5);
      step(0, 4'h0, 4'h0, 0, 3'd0, 8'h00, 3'd0, 3'd5);
      check("cdb_unocc_ready", rd_ready_b, 0);
      check("cdb_unocc_count", count, 0);

`ifdef ROB_DUAL_RETIRE_EN
      t = m_next;
      step(1, 4'h1, 4'h1, 0, 3'd0, 8'h00, 3'd0, 3'd0);
      step(1, 4'h1, 4'h2, 0, 3'd0, 8'h00, 3'd0, 3'd0);
      step(0, 4'h0, 4'h0, 1, 3'((t + 1) % 8), 8'hB2, 3'd0, 3'd0);
      step(0, 4'h0, 4'h0, 1, 3'(t), 8'hB1, 3'd0, 3'd0);
      check("dual_pre_count", count, 2);
      idle(1);
      check("dual_v0", ret_valid, 1);
      check("dual_v1", ret1_valid, 1);
      check("dual_count", count, 0);
`endif

      // Random traffic against the model, with one asynchronous reset partway through.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) async_reset();
         av = ($urandom_range(0, 9) < 7);
         cv = ($urandom_range(0, 9) < 6);
         ct = 3'($urandom_range(0, 7));
         if (m_done[ct] && ((m_order.size() > 0 && m_order[0] == ct) ||
                            (m_order.size() > 1 && m_order[1] == ct)))
            cv = 1'b0;
         step(av, 4'($urandom_range(0, 5)), 4'($urandom), cv, ct, 8'($urandom),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer storage and in-order retire stage of the Tomasulo core. Accepts allocations from the issue stage at the tail, absorbs completion broadcasts from the common data bus (CDB), and drains completed entries from the head in program order. Each drain presents a register-file write (or a store-commit pulse to the LSQ) plus the retiring tag, so the register file can clear its rename pointer. Serves reservation-station operand lookups through two combinational read ports.

## Interface
- DEPTH, 8, ROB entries (power of two; tag width = log2(DEPTH) = 3)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  issue requests an entry this cycle
- alloc_ready  out  1  high when count < DEPTH
- alloc_opcode  in  4  instruction opcode (0000 sub … 0101 load)
- alloc_dest  in  4  architectural destination register
- alloc_tag  out  3  tag that an accepted allocation receives (= tail)
- cdb_valid  in  1  completion broadcast
- cdb_tag  in  3  completing ROB tag
- cdb_value  in  8  result byte
- rd_tag_a / rd_tag_b  in  3  operand lookup tags
- rd_ready_a / rd_ready_b  out  1  entry occupied and done
- rd_value_a / rd_value_b  out  8  entry value (0 when not ready)
- ret_valid  out  1  one-cycle retire pulse, lane 0
- ret_tag  out  3  retiring tag
- ret_dest  out  4  destination register
- ret_value  out  8  result byte
- ret_is_store  out  1  opcode was 0100; register file ignores, LSQ commits
- ret1_valid / ret1_tag / ret1_dest / ret1_value / ret1_is_store  out  1/3/4/8/1  lane 1, present only with ROB_DUAL_RETIRE_EN
- count  out  4  occupied entries, 0..8
- empty  out  1  count == 0

## Operation
- Per entry: occupied, done, opcode, dest, value.
- Allocate: on posedge with alloc_valid && alloc_ready, write entry[tail], occupied=1, done=0, value=0; tail wraps 7→0. alloc_valid while full is ignored and leaves no state change.
- Complete: on posedge with cdb_valid, if entry[cdb_tag].occupied, set done=1 and value=cdb_value. A CDB hit on an unoccupied tag is ignored. A second CDB hit to a done entry overwrites value.
- Retire: on posedge, if entry[head] is occupied and done, clear occupied, advance head (wrap), and register the entry into ret_* with ret_valid=1; otherwise ret_valid=0 (ret_* hold their last values).
- count = count + alloc_accept − retired; alloc and retire on the same edge leave count unchanged. When full, retire frees a slot visible on alloc_ready the next cycle. No same-cycle reuse.
- Read ports are purely combinational from registered state. No CDB forwarding.
- Reset: head=tail=0, count=0, all occupied/done=0, ret_valid=0, ret_tag/dest/value/is_store=0, alloc_ready=1, empty=1.

## Timing
- Allocation visible to the read ports in the cycle after the accepting edge.
- CDB write at edge N. Earliest retire at edge N+1. ret_valid is high for the cycle following N+1.
- CDB on head tag and retire of head never occur on the same edge.
- Throughput: 1 retire/cycle (2 with macro), 1 alloc/cycle.
- Reset mid-operation discards all entries immediately. No retire pulse is emitted.

## Configuration
- ROB_DUAL_RETIRE_EN defined: if head retires and entry[head+1] is also occupied and done on that edge, it retires in the same edge on lane 1. Head advances by 2 and count drops by 2. Lane 1 never fires without lane 0.
- Undefined: lane 1 ports are absent. Single retire only.

## Structure
- Shared package rob_pkg: ROB_DEPTH, TAG_W, opcode constants OPC_SUB…OPC_LOAD (OPC_STORE=4'b0100), and the rob_entry_t struct.
- One sub-module, rob_ptr: modular head/tail pointer with increment-by-k and async reset.

## Test plan
- Reset, then 8 allocs (dest 1..8), no CDB → alloc_tag 0..7, count=8, alloc_ready=0. A 9th alloc is ignored.
- Alloc tags 0,1. CDB tag1=0x22 then tag0=0x11 → single retire pulses in order: tag0/0x11, then tag1/0x22. empty=1 afterwards.
- Full ROB with head done. Alloc on the retire edge → rejected. Alloc on the next cycle is accepted with tag 0 after wrap.
- Store (opcode 0100, dest 3) completes → ret_valid=1, ret_is_store=1, ret_dest=3.
- rd_tag_a = pending tag → rd_ready_a=0. After CDB 0x5A → rd_ready_a=1, rd_value_a=0x5A. CDB to an unoccupied tag → no state change.
- With ROB_DUAL_RETIRE_EN: tags 0,1 both done → ret_valid and ret1_valid are high in the same cycle, and count drops by 2. Assert rst_n mid-run → count=0 and ret_valid=0 asynchronously.
